// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: forwarding, stalls, flushes, memory wait FSM.
// Optional PERF_CNT_EN adds saturating stall/flush event counters.
module pipeline_ctrl #(
    parameter int MEM_WAIT = 2,
    parameter int RA_W     = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [RA_W-1:0] Ra1D,
    input  logic [RA_W-1:0] Ra2D,
    input  logic [RA_W-1:0] Ra1E,
    input  logic [RA_W-1:0] Ra2E,
    input  logic [RA_W-1:0] WA3E,
    input  logic [RA_W-1:0] WA3M,
    input  logic [RA_W-1:0] WA3W,
    input  logic            RegWriteM,
    input  logic            RegWriteW,
    input  logic            MemtoRegE,
    input  logic            MemAccessM,
    input  logic            PCSrcD,
    input  logic            PCSrcE,
    input  logic            PCSrcM,
    input  logic            PCSrcW,
    input  logic            BranchTakenE,
    output logic [1:0]      ForwardAE,
    output logic [1:0]      ForwardBE,
    output logic            StallF,
    output logic            StallD,
    output logic            StallE,
    output logic            StallM,
    output logic            FlushD,
    output logic            FlushE,
    output logic            FlushW,
    output logic            MemBusy
`ifdef PERF_CNT_EN
    ,
    output logic [15:0]     StallCnt,
    output logic [15:0]     FlushCnt
`endif
);

    //  state  | meaning
    //  S_IDLE | no memory wait; a new access in M may start one
    //  S_WAIT | M frozen; cnt counts remaining stall cycles, cnt==0 is the release cycle
    typedef enum logic {S_IDLE, S_WAIT} memState_t;

    localparam int CNT_W = (MEM_WAIT > 3) ? $clog2(MEM_WAIT) : 2;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MEM_WAIT > 0) ? MEM_WAIT - 1 : 0);
    localparam logic HAS_WAIT = (MEM_WAIT > 0);

    memState_t        state;
    logic [CNT_W-1:0] cnt;
    logic             memStall;
    logic             ldrStall;
    logic             pcPend;

    always_comb begin
        ForwardAE = 2'b00;
        if (RegWriteM && (Ra1E == WA3M))
            ForwardAE = 2'b10;
        else if (RegWriteW && (Ra1E == WA3W))
            ForwardAE = 2'b01;
    end

    always_comb begin
        ForwardBE = 2'b00;
        if (RegWriteM && (Ra2E == WA3M))
            ForwardBE = 2'b10;
        else if (RegWriteW && (Ra2E == WA3W))
            ForwardBE = 2'b01;
    end

    assign ldrStall = MemtoRegE & ((Ra1D == WA3E) | (Ra2D == WA3E));
    assign pcPend   = PCSrcD | PCSrcE | PCSrcM;

    // Gated by reset so MemBusy falls the instant reset asserts, independent of inputs.
    always_comb begin
        memStall = 1'b0;
        if (reset) begin
            case (state)
                S_IDLE:  memStall = MemAccessM & HAS_WAIT;
                S_WAIT:  memStall = (cnt != '0);
                default: memStall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (MemAccessM && HAS_WAIT) begin
                        state <= S_WAIT;
                        cnt   <= CNT_LOAD;
                    end
                end
                S_WAIT: begin
                    if (cnt != '0)
                        cnt <= cnt - 1'b1;
                    else
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign StallM  = memStall;
    assign StallE  = memStall;
    assign StallD  = memStall | ldrStall;
    assign StallF  = memStall | ldrStall | pcPend;
    assign FlushW  = memStall;
    assign FlushE  = ~memStall & (ldrStall | BranchTakenE);
    assign FlushD  = ~memStall & (pcPend | PCSrcW | BranchTakenE);
    assign MemBusy = memStall;

`ifdef PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (StallF && (StallCnt != 16'hFFFF))
                StallCnt <= StallCnt + 16'd1;
            if (FlushE && (FlushCnt != 16'hFFFF))
                FlushCnt <= FlushCnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: table-driven hazard vectors plus multi-cycle memory/branch/reset sequences.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Ra1D, Ra2D, Ra1E, Ra2E, WA3E, WA3M, WA3W;
    logic       RegWriteM, RegWriteW, MemtoRegE, MemAccessM;
    logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemBusy;
`ifdef PERF_CNT_EN
    logic [15:0] StallCnt, FlushCnt;
`endif

    pipeline_ctrl #(.MEM_WAIT(2), .RA_W(4)) dut (
        .clk(clk), .reset(reset),
        .Ra1D(Ra1D), .Ra2D(Ra2D), .Ra1E(Ra1E), .Ra2E(Ra2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemAccessM(MemAccessM),
        .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
        .BranchTakenE(BranchTakenE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemBusy(MemBusy)
`ifdef PERF_CNT_EN
        , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
    );

    always #5 clk = ~clk;

    // {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemBusy}
    logic [11:0] outs;
    assign outs = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                   FlushD, FlushE, FlushW, MemBusy};

    typedef struct {
        string       name;
        logic [3:0]  ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
        logic        rwm, rww, mtr, bte, pcd, pce, pcm, pcw;
        logic [11:0] exp;
    } vec_t;

    vec_t        vecs[16];
    logic [11:0] sbq[$];
    int          compared   = 0;
    int          mismatched = 0;

    task automatic zeroInputs();
        {Ra1D, Ra2D, Ra1E, Ra2E, WA3E, WA3M, WA3W} = '0;
        {RegWriteM, RegWriteW, MemtoRegE, MemAccessM} = '0;
        {PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE} = '0;
    endtask

    task automatic checkNow(string name);
        logic [11:0] e;
        compared++;
        if (sbq.size() == 0) begin
            mismatched++;
            $display("FAIL %s: scoreboard empty, got %b", name, outs);
        end else begin
            e = sbq.pop_front();
            if (outs !== e) begin
                mismatched++;
                $display("FAIL %s: got %b expected %b", name, outs, e);
            end
        end
    endtask

    // Inputs are already applied; sample mid-cycle, then move to just after the next edge.
    task automatic step(string name, logic [11:0] exp);
        sbq.push_back(exp);
        @(negedge clk);
        checkNow(name);
        @(posedge clk);
        #1;
    endtask

    task automatic checkVal(string name, logic [15:0] act, logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulseReset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    localparam logic [11:0] ZERO  = 12'b00_00_0000_000_0;
    localparam logic [11:0] MSTL  = 12'b00_00_1111_001_1;
    localparam logic [11:0] PCST  = 12'b00_00_1000_100_0;

    initial begin
        //          name          ra1d ra2d ra1e ra2e wa3e wa3m wa3w rwm rww mtr bte pcd pce pcm pcw exp
        vecs[0]  = '{"all_zero",   0, 0, 0, 0, 0, 0, 0,  0,0,0,0,0,0,0,0, 12'b00_00_0000_000_0};
        vecs[1]  = '{"fwdA_M",     0, 0, 3, 0, 0, 3, 3,  1,1,0,0,0,0,0,0, 12'b10_00_0000_000_0};
        vecs[2]  = '{"fwdA_W",     0, 0, 3, 0, 0, 3, 3,  0,1,0,0,0,0,0,0, 12'b01_00_0000_000_0};
        vecs[3]  = '{"fwdB_M",     0, 0, 0, 7, 0, 7, 0,  1,0,0,0,0,0,0,0, 12'b00_10_0000_000_0};
        vecs[4]  = '{"fwdAB_W",    0, 0, 4, 4, 0, 4, 4,  0,1,0,0,0,0,0,0, 12'b01_01_0000_000_0};
        vecs[5]  = '{"fwd_mixed",  0, 0, 2, 9, 0, 9, 2,  1,1,0,0,0,0,0,0, 12'b01_10_0000_000_0};
        vecs[6]  = '{"fwd_none",   0, 0, 5, 0, 0, 6, 7,  1,1,0,0,0,0,0,0, 12'b00_00_0000_000_0};
        vecs[7]  = '{"ldr_ra2d",   0, 5, 0, 0, 5, 0, 0,  0,0,1,0,0,0,0,0, 12'b00_00_1100_010_0};
        vecs[8]  = '{"ldr_ra1d",   6, 1, 0, 0, 6, 0, 0,  0,0,1,0,0,0,0,0, 12'b00_00_1100_010_0};
        vecs[9]  = '{"noload",     0, 5, 0, 0, 5, 0, 0,  0,0,0,0,0,0,0,0, 12'b00_00_0000_000_0};
        vecs[10] = '{"load_nodep", 1, 2, 0, 0, 5, 0, 0,  0,0,1,0,0,0,0,0, 12'b00_00_0000_000_0};
        vecs[11] = '{"branch",     0, 0, 0, 0, 0, 0, 0,  0,0,0,1,0,0,0,0, 12'b00_00_0000_110_0};
        vecs[12] = '{"ldr_branch", 0, 5, 0, 0, 5, 0, 0,  0,0,1,1,0,0,0,0, 12'b00_00_1100_110_0};
        vecs[13] = '{"pcsrcD",     0, 0, 0, 0, 0, 0, 0,  0,0,0,0,1,0,0,0, 12'b00_00_1000_100_0};
        vecs[14] = '{"pcsrcW",     0, 0, 0, 0, 0, 0, 0,  0,0,0,0,0,0,0,1, 12'b00_00_0000_100_0};
        vecs[15] = '{"pcsrcM",     0, 0, 0, 0, 0, 0, 0,  0,0,0,0,0,0,1,0, 12'b00_00_1000_100_0};

        zeroInputs();
        reset = 1'b0;
        #2;
        sbq.push_back(ZERO);
        checkNow("reset_state");
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            Ra1D = vecs[i].ra1d; Ra2D = vecs[i].ra2d;
            Ra1E = vecs[i].ra1e; Ra2E = vecs[i].ra2e;
            WA3E = vecs[i].wa3e; WA3M = vecs[i].wa3m; WA3W = vecs[i].wa3w;
            RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww;
            MemtoRegE = vecs[i].mtr; BranchTakenE = vecs[i].bte;
            PCSrcD = vecs[i].pcd; PCSrcE = vecs[i].pce;
            PCSrcM = vecs[i].pcm; PCSrcW = vecs[i].pcw;
            MemAccessM = 1'b0;
            step(vecs[i].name, vecs[i].exp);
        end

        // Memory wait with a simultaneous taken branch: flushes suppressed until release.
        zeroInputs();
        pulseReset();
        MemAccessM = 1'b1; BranchTakenE = 1'b1;
        step("mem_br_c1", MSTL);
        step("mem_br_c2", MSTL);
        step("mem_br_release", 12'b00_00_0000_110_0);
        zeroInputs();
        step("mem_br_after", ZERO);
`ifdef PERF_CNT_EN
        checkVal("stall_cnt", StallCnt, 16'd2);
        checkVal("flush_cnt", FlushCnt, 16'd1);
`endif

        // PC-writing instruction walking D->E->M->W.
        PCSrcD = 1'b1;
        step("pc_D", PCST);
        PCSrcD = 1'b0; PCSrcE = 1'b1;
        step("pc_E", PCST);
        PCSrcE = 1'b0; PCSrcM = 1'b1;
        step("pc_M", PCST);
        PCSrcM = 1'b0; PCSrcW = 1'b1;
        step("pc_W", 12'b00_00_0000_100_0);
        PCSrcW = 1'b0;
        step("pc_done", ZERO);

        // Reset asserted in the middle of a wait.
        MemAccessM = 1'b1;
        step("rst_c1", MSTL);
        MemAccessM = 1'b0;
        sbq.push_back(MSTL);
        @(negedge clk);
        checkNow("rst_c2_wait");
        #1;
        reset = 1'b0;
        #1;
        sbq.push_back(ZERO);
        checkNow("rst_async_busy");
        @(posedge clk);
        #1;
        reset = 1'b1;
        step("post_rst_1", ZERO);
        step("post_rst_2", ZERO);

        // Fresh access after reset; MemAccessM dropped while waiting is ignored.
        MemAccessM = 1'b1;
        step("again_c1", MSTL);
        MemAccessM = 1'b0;
        step("again_c2", MSTL);
        step("again_release", ZERO);
        step("again_idle", ZERO);

        if (sbq.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sbq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
